// File: rtl/ram_pkg.sv
// Shared definitions for the 1-write / N-read RAM: read-under-write encodings,
// address-width helper and the byte-lane merge used by the write bypass.
package ram_pkg;

    localparam int RUW_INVALID    = -1;
    localparam int RUW_DONTCARE   = 0;
    localparam int RUW_READFIRST  = 1;
    localparam int RUW_WRITEFIRST = 2;

    // Widest word the lane-merge helper handles; callers zero-extend into it.
    localparam int MAX_WORD_W = 512;
    localparam int MAX_IDX_W  = 9;

    // Read-under-write mode is passed as a string literal held in a wide vector.
    typedef logic [127:0] ruw_str_t;

    function automatic int ruw_encode(input ruw_str_t s);
        if (s == ruw_str_t'("dontCare"))   return RUW_DONTCARE;
        if (s == ruw_str_t'("readFirst"))  return RUW_READFIRST;
        if (s == ruw_str_t'("writeFirst")) return RUW_WRITEFIRST;
        return RUW_INVALID;
    endfunction

    // ceil(log2(n)), but never below one bit so a single-word RAM still has an address.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Lanes whose mask bit is set come from new_w, all others from old_w.
    function automatic logic [MAX_WORD_W-1:0] lane_merge(
        input logic [MAX_WORD_W-1:0] old_w,
        input logic [MAX_WORD_W-1:0] new_w,
        input logic [MAX_WORD_W-1:0] mask,
        input int                    lane_w
    );
        logic [MAX_WORD_W-1:0] r;
        logic [MAX_IDX_W-1:0]  li;
        r = old_w;
        for (int b = 0; b < MAX_WORD_W; b++) begin
            li = MAX_IDX_W'(b / lane_w);
            if (mask[li]) r[b] = new_w[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_1w_nrs_bypass_if.sv
// Write and multi-port read bus of the 1-write / N-read RAM.
interface ram_1w_nrs_bypass_if #(
    parameter int addrWidth = 8,
    parameter int wordWidth = 32,
    parameter int maskWidth = 4,
    parameter int readPorts = 2
);
    logic                           wr_en;
    logic [maskWidth-1:0]           wr_mask;
    logic [addrWidth-1:0]           wr_addr;
    logic [wordWidth-1:0]           wr_data;
    logic [readPorts-1:0]           rd_en;
    logic [readPorts*addrWidth-1:0] rd_addr;
    logic [readPorts*wordWidth-1:0] rd_data;
    logic [readPorts-1:0]           rd_valid;

    modport master (
        output wr_en, wr_mask, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_mask, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/ram_rd_port.sv
// One read port: range check, same-edge write collision bypass, and a 1- or
// 2-stage result pipeline with a valid bit travelling alongside the data.
module ram_rd_port
    import ram_pkg::*;
#(
    parameter int wordCount = 256,
    parameter int addrWidth = 8,
    parameter int wordWidth = 32,
    parameter int maskWidth = 4,
    parameter int rdLatency = 1,
    parameter int ruwMode   = RUW_WRITEFIRST
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 rd_en_i,
    input  logic [addrWidth-1:0] rd_addr_i,
    input  logic [wordWidth-1:0] arr_word_i,
    input  logic                 wr_en_i,
    input  logic [maskWidth-1:0] wr_mask_i,
    input  logic [addrWidth-1:0] wr_addr_i,
    input  logic [wordWidth-1:0] wr_data_i,
    output logic [wordWidth-1:0] rd_data_o,
    output logic                 rd_valid_o
);
    localparam int laneWidth = wordWidth / maskWidth;

    logic                 in_range;
    logic                 collide;
    logic [maskWidth-1:0] bypass_mask;
    logic [wordWidth-1:0] merged;
    logic [wordWidth-1:0] data_p1_d;
    logic [wordWidth-1:0] data_p1_q;
    logic                 vld_p1_q;

    assign in_range = int'(rd_addr_i) < wordCount;
    assign collide  = wr_en_i && (wr_addr_i == rd_addr_i);

    // Only writeFirst forwards the write lanes; readFirst and dontCare see the pre-write word.
    assign bypass_mask = (collide && ruwMode == RUW_WRITEFIRST) ? wr_mask_i : '0;
    assign merged      = wordWidth'(lane_merge(MAX_WORD_W'(arr_word_i), MAX_WORD_W'(wr_data_i),
                                               MAX_WORD_W'(bypass_mask), laneWidth));

    // Out-of-range addresses read as zero; the valid bit is unaffected.
    always_comb begin
        data_p1_d = '0;
        if (in_range) data_p1_d = merged;
    end

    // Stage 1: capture the array word; data holds while the port is idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_p1_q <= '0;
            vld_p1_q  <= 1'b0;
        end else begin
            vld_p1_q <= rd_en_i;
            if (rd_en_i) data_p1_q <= data_p1_d;
        end
    end

    if (rdLatency == 2) begin : g_lat2
        logic [wordWidth-1:0] data_p2_q;
        logic                 vld_p2_q;

        // Stage 2: plain delay, no stall; later writes cannot reach data already in flight.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                data_p2_q <= '0;
                vld_p2_q  <= 1'b0;
            end else begin
                vld_p2_q <= vld_p1_q;
                if (vld_p1_q) data_p2_q <= data_p1_q;
            end
        end

        assign rd_data_o  = data_p2_q;
        assign rd_valid_o = vld_p2_q;
    end else begin : g_lat1
        assign rd_data_o  = data_p1_q;
        assign rd_valid_o = vld_p1_q;
    end

endmodule

// File: rtl/ram_1w_nrs_bypass.sv
// Single-clock 1-write / N-read RAM with byte-lane write mask, selectable read
// latency and defined read-under-write behaviour. Holds the array and write
// logic; each read port is a ram_rd_port instance.
module ram_1w_nrs_bypass
    import ram_pkg::*;
#(
    parameter int       wordCount      = 256,
    parameter int       wordWidth      = 32,
    parameter int       maskWidth      = 4,
    parameter int       readPorts      = 2,
    parameter int       rdLatency      = 1,
    parameter ruw_str_t readUnderWrite = "writeFirst"
) (
    input  logic              clk,
    input  logic              resetn,
    ram_1w_nrs_bypass_if.slave bus
);
    localparam int addrWidth = clog2_min1(wordCount);
    localparam int laneWidth = wordWidth / maskWidth;
    localparam int ruwMode   = ruw_encode(readUnderWrite);

    if (rdLatency != 1 && rdLatency != 2) begin : g_bad_latency
        $fatal(1, "ram_1w_nrs_bypass: rdLatency must be 1 or 2");
    end
    if (maskWidth < 1 || (wordWidth % maskWidth) != 0) begin : g_bad_mask
        $fatal(1, "ram_1w_nrs_bypass: wordWidth must be divisible by maskWidth");
    end
    if (ruwMode == RUW_INVALID) begin : g_bad_ruw
        $fatal(1, "ram_1w_nrs_bypass: unknown readUnderWrite mode");
    end
    if (readPorts < 1 || readPorts > 4) begin : g_bad_ports
        $fatal(1, "ram_1w_nrs_bypass: readPorts must be 1..4");
    end
    if (wordWidth > MAX_WORD_W) begin : g_bad_width
        $fatal(1, "ram_1w_nrs_bypass: wordWidth exceeds lane-merge limit");
    end

    logic [wordWidth-1:0] mem_q [wordCount];
    logic                 wr_in_range;

    assign wr_in_range = int'(bus.wr_addr) < wordCount;

    // Lane-masked array write; the array is never reset and out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (bus.wr_en && wr_in_range) begin
            for (int i = 0; i < maskWidth; i++) begin
                if (bus.wr_mask[i]) begin
                    mem_q[bus.wr_addr][i*laneWidth +: laneWidth] <= bus.wr_data[i*laneWidth +: laneWidth];
                end
            end
        end
    end

    for (genvar p = 0; p < readPorts; p++) begin : g_port
        logic [addrWidth-1:0] addr_p;
        logic [wordWidth-1:0] word_p;
        logic [wordWidth-1:0] data_p;
        logic                 valid_p;

        assign addr_p = bus.rd_addr[p*addrWidth +: addrWidth];
        assign word_p = mem_q[addr_p];

        ram_rd_port #(
            .wordCount (wordCount),
            .addrWidth (addrWidth),
            .wordWidth (wordWidth),
            .maskWidth (maskWidth),
            .rdLatency (rdLatency),
            .ruwMode   (ruwMode)
        ) u_rd_port (
            .clk        (clk),
            .resetn     (resetn),
            .rd_en_i    (bus.rd_en[p]),
            .rd_addr_i  (addr_p),
            .arr_word_i (word_p),
            .wr_en_i    (bus.wr_en),
            .wr_mask_i  (bus.wr_mask),
            .wr_addr_i  (bus.wr_addr),
            .wr_data_i  (bus.wr_data),
            .rd_data_o  (data_p),
            .rd_valid_o (valid_p)
        );

        assign bus.rd_data[p*wordWidth +: wordWidth] = data_p;
        assign bus.rd_valid[p]                       = valid_p;
    end

endmodule

// File: tb/tb_ram_1w_nrs_bypass.sv
// Bench for ram_1w_nrs_bypass: two builds side by side
//   A: 256 words, rdLatency=1, writeFirst
//   B: 200 words, rdLatency=2, readFirst
// Table-driven directed vectors on A, random traffic on both against a
// memory-array/result-queue reference model, and directed corner sequences on B.
module tb_ram_1w_nrs_bypass;
    import ram_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // Bench-side drive variables, index 0 = build A, 1 = build B.
    logic          d_wr_en   [2];
    logic [MW-1:0] d_wr_mask [2];
    logic [AW-1:0] d_wr_addr [2];
    logic [DW-1:0] d_wr_data [2];
    logic [NP-1:0] d_rd_en   [2];
    logic [AW-1:0] d_rd_addr [2][NP];

    ram_1w_nrs_bypass_if #(.addrWidth(AW), .wordWidth(DW), .maskWidth(MW), .readPorts(NP)) ifA ();
    ram_1w_nrs_bypass_if #(.addrWidth(AW), .wordWidth(DW), .maskWidth(MW), .readPorts(NP)) ifB ();

    assign ifA.wr_en   = d_wr_en[0];
    assign ifA.wr_mask = d_wr_mask[0];
    assign ifA.wr_addr = d_wr_addr[0];
    assign ifA.wr_data = d_wr_data[0];
    assign ifA.rd_en   = d_rd_en[0];
    assign ifA.rd_addr = {d_rd_addr[0][1], d_rd_addr[0][0]};
    assign ifB.wr_en   = d_wr_en[1];
    assign ifB.wr_mask = d_wr_mask[1];
    assign ifB.wr_addr = d_wr_addr[1];
    assign ifB.wr_data = d_wr_data[1];
    assign ifB.rd_en   = d_rd_en[1];
    assign ifB.rd_addr = {d_rd_addr[1][1], d_rd_addr[1][0]};

    ram_1w_nrs_bypass #(
        .wordCount(256), .wordWidth(DW), .maskWidth(MW), .readPorts(NP),
        .rdLatency(1), .readUnderWrite("writeFirst")
    ) u_a (
        .clk(clk), .resetn(resetn), .bus(ifA)
    );

    ram_1w_nrs_bypass #(
        .wordCount(200), .wordWidth(DW), .maskWidth(MW), .readPorts(NP),
        .rdLatency(2), .readUnderWrite("readFirst")
    ) u_b (
        .clk(clk), .resetn(resetn), .bus(ifB)
    );

    // ---------------- reference model ----------------
    int lat_m [2];
    int wc_m  [2];
    bit wf_m  [2];

    logic [DW-1:0] mem_m   [2][256];
    bit            known_m [2][256];

    typedef struct {
        int            due;
        logic [DW-1:0] d;
        bit            k;
    } pend_t;

    pend_t         pq    [4][$];
    bit            exp_v [4];
    logic [DW-1:0] exp_d [4];
    bit            exp_k [4];

    int cyc;
    int n_cmp;
    int n_bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] out_d(input int d, input int p);
        if (d == 0) return ifA.rd_data[p*DW +: DW];
        return ifB.rd_data[p*DW +: DW];
    endfunction

    function automatic logic out_v(input int d, input int p);
        if (d == 0) return ifA.rd_valid[p];
        return ifB.rd_valid[p];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            pq[i].delete();
            exp_v[i] = 1'b0;
            exp_d[i] = '0;
            exp_k[i] = 1'b1;
        end
    endtask

    // One rising edge seen by the model: sample reads (with collision rule), retire due results, apply writes.
    task automatic model_edge();
        cyc++;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NP; p++) begin
                if (resetn && d_rd_en[d][p]) begin
                    int    a;
                    pend_t e;
                    a     = int'(d_rd_addr[d][p]);
                    e.due = cyc + lat_m[d] - 1;
                    if (a >= wc_m[d]) begin
                        e.d = '0;
                        e.k = 1'b1;
                    end else begin
                        e.d = mem_m[d][a];
                        e.k = known_m[d][a];
                        if (wf_m[d] && d_wr_en[d] && int'(d_wr_addr[d]) == a) begin
                            for (int l = 0; l < MW; l++)
                                if (d_wr_mask[d][l]) e.d[l*8 +: 8] = d_wr_data[d][l*8 +: 8];
                            if (d_wr_mask[d] == 4'hF) e.k = 1'b1;
                        end
                    end
                    pq[d*NP+p].push_back(e);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            exp_v[i] = 1'b0;
            if (pq[i].size() != 0 && pq[i][0].due == cyc) begin
                exp_v[i] = 1'b1;
                exp_d[i] = pq[i][0].d;
                exp_k[i] = pq[i][0].k;
                void'(pq[i].pop_front());
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (d_wr_en[d] && int'(d_wr_addr[d]) < wc_m[d]) begin
                int a;
                a = int'(d_wr_addr[d]);
                for (int l = 0; l < MW; l++)
                    if (d_wr_mask[d][l]) mem_m[d][a][l*8 +: 8] = d_wr_data[d][l*8 +: 8];
                if (d_wr_mask[d] == 4'hF) known_m[d][a] = 1'b1;
            end
        end
    endtask

    task automatic compare_model();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NP; p++) begin
                int i;
                i = d*NP + p;
                check($sformatf("model_valid dut%0d port%0d cyc%0d", d, p, cyc),
                      64'(out_v(d, p)), 64'(exp_v[i]));
                if (exp_k[i])
                    check($sformatf("model_data dut%0d port%0d cyc%0d", d, p, cyc),
                          64'(out_d(d, p)), 64'(exp_d[i]));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic idle(input int d);
        d_wr_en[d]   = 1'b0;
        d_wr_mask[d] = '0;
        d_wr_addr[d] = '0;
        d_wr_data[d] = '0;
        d_rd_en[d]   = '0;
        for (int p = 0; p < NP; p++) d_rd_addr[d][p] = '0;
    endtask

    task automatic wr(input int d, input int a, input logic [DW-1:0] data, input logic [MW-1:0] m);
        d_wr_en[d]   = 1'b1;
        d_wr_addr[d] = AW'(a);
        d_wr_data[d] = data;
        d_wr_mask[d] = m;
    endtask

    // ---------------- directed table for build A ----------------
    typedef struct {
        logic          we;
        logic [MW-1:0] wm;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [NP-1:0] re;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [NP-1:0] ev;
        logic [DW-1:0] ed0;
        logic [DW-1:0] ed1;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 4'hF, 8'd5, 32'hAABBCCDD, 2'b00, 8'd0, 8'd0, 2'b00, 32'h00000000, 32'h00000000};
        tbl[1] = '{1'b1, 4'h2, 8'd5, 32'h11223344, 2'b00, 8'd0, 8'd0, 2'b00, 32'h00000000, 32'h00000000};
        tbl[2] = '{1'b0, 4'h0, 8'd0, 32'h00000000, 2'b11, 8'd5, 8'd5, 2'b11, 32'hAABB33DD, 32'hAABB33DD};
        tbl[3] = '{1'b1, 4'hF, 8'd7, 32'h01020304, 2'b00, 8'd0, 8'd0, 2'b00, 32'hAABB33DD, 32'hAABB33DD};
        tbl[4] = '{1'b1, 4'h5, 8'd7, 32'hFFFFFFFF, 2'b01, 8'd7, 8'd0, 2'b01, 32'h01FF03FF, 32'hAABB33DD};
        tbl[5] = '{1'b1, 4'h0, 8'd7, 32'hDEADBEEF, 2'b10, 8'd0, 8'd7, 2'b10, 32'h01FF03FF, 32'h01FF03FF};
        tbl[6] = '{1'b0, 4'h0, 8'd0, 32'h00000000, 2'b11, 8'd7, 8'd5, 2'b11, 32'h01FF03FF, 32'hAABB33DD};
        tbl[7] = '{1'b1, 4'h8, 8'd5, 32'h00000000, 2'b11, 8'd7, 8'd5, 2'b11, 32'h01FF03FF, 32'h00BB33DD};
        tbl[8] = '{1'b0, 4'h0, 8'd0, 32'h00000000, 2'b00, 8'd0, 8'd0, 2'b00, 32'h01FF03FF, 32'h00BB33DD};
        tbl[9] = '{1'b0, 4'h0, 8'd0, 32'h00000000, 2'b10, 8'd0, 8'd5, 2'b10, 32'h01FF03FF, 32'h00BB33DD};

        lat_m[0] = 1;   wc_m[0] = 256; wf_m[0] = 1'b1;
        lat_m[1] = 2;   wc_m[1] = 200; wf_m[1] = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 256; a++) begin
                mem_m[d][a]   = '0;
                known_m[d][a] = 1'b0;
            end
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;

        // Reset with both ports requesting reads: nothing may come out.
        resetn = 1'b0;
        idle(0);
        idle(1);
        for (int d = 0; d < 2; d++) begin
            d_rd_en[d]      = 2'b11;
            d_rd_addr[d][0] = 8'd0;
            d_rd_addr[d][1] = 8'd1;
        end
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_valid_a", 64'(ifA.rd_valid), 64'h0);
            check("reset_data_a",  64'(ifA.rd_data),  64'h0);
            check("reset_valid_b", 64'(ifB.rd_valid), 64'h0);
            check("reset_data_b",  64'(ifB.rd_data),  64'h0);
        end
        @(negedge clk);
        resetn = 1'b1;
        idle(0);
        idle(1);

        // Directed vectors on A (latency 1, writeFirst).
        for (int r = 0; r < 10; r++) begin
            d_wr_en[0]      = tbl[r].we;
            d_wr_mask[0]    = tbl[r].wm;
            d_wr_addr[0]    = tbl[r].wa;
            d_wr_data[0]    = tbl[r].wd;
            d_rd_en[0]      = tbl[r].re;
            d_rd_addr[0][0] = tbl[r].ra0;
            d_rd_addr[0][1] = tbl[r].ra1;
            step();
            check($sformatf("tbl%0d_valid", r), 64'(ifA.rd_valid),          64'(tbl[r].ev));
            check($sformatf("tbl%0d_data0", r), 64'(ifA.rd_data[31:0]),     64'(tbl[r].ed0));
            check($sformatf("tbl%0d_data1", r), 64'(ifA.rd_data[63:32]),    64'(tbl[r].ed1));
        end
        idle(0);

        // Fill both arrays so every in-range word is known to the model.
        for (int a = 0; a < 256; a++) begin
            wr(0, a, $urandom, 4'hF);
            wr(1, a, $urandom, 4'hF);
            step();
        end
        idle(0);
        idle(1);

        // Random traffic with frequent same-address read/write collisions.
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 2; d++) begin
                d_wr_en[d]   = 1'($urandom_range(0, 1));
                d_wr_mask[d] = MW'($urandom);
                d_wr_addr[d] = AW'($urandom);
                d_wr_data[d] = $urandom;
                d_rd_en[d]   = NP'($urandom);
                for (int p = 0; p < NP; p++)
                    d_rd_addr[d][p] = ($urandom_range(0, 2) == 0) ? d_wr_addr[d] : AW'($urandom);
            end
            step();
        end
        idle(0);
        idle(1);
        step();
        step();

        // B, readFirst collision returns the pre-write word; the write still lands.
        wr(1, 7, 32'h01020304, 4'hF);
        step();
        wr(1, 7, 32'hFFFFFFFF, 4'h5);
        d_rd_en[1] = 2'b01;
        d_rd_addr[1][0] = 8'd7;
        step();
        idle(1);
        step();
        check("rf_coll_valid", 64'(ifB.rd_valid),      64'h1);
        check("rf_coll_data",  64'(ifB.rd_data[31:0]), 64'h01020304);
        d_rd_en[1] = 2'b01;
        d_rd_addr[1][0] = 8'd7;
        step();
        idle(1);
        step();
        check("rf_after_data", 64'(ifB.rd_data[31:0]), 64'h01FF03FF);
        step();
        check("rf_single_valid", 64'(ifB.rd_valid), 64'h0);

        // B, 200 words: out-of-range write dropped, out-of-range read gives zero with valid.
        wr(1, 250, 32'h12345678, 4'hF);
        step();
        wr(1, 199, 32'hCAFEF00D, 4'hF);
        step();
        idle(1);
        d_rd_en[1] = 2'b11;
        d_rd_addr[1][0] = 8'd250;
        d_rd_addr[1][1] = 8'd199;
        step();
        idle(1);
        step();
        check("oor_valid",  64'(ifB.rd_valid),       64'h3);
        check("oor_data0",  64'(ifB.rd_data[31:0]),  64'h0);
        check("last_data1", 64'(ifB.rd_data[63:32]), 64'hCAFEF00D);

        // B, latency 2 back-to-back reads; a write during the second stage leaves the result alone.
        wr(1, 1, 32'h00000111, 4'hF);
        step();
        wr(1, 2, 32'h00000222, 4'hF);
        step();
        wr(1, 3, 32'h00000333, 4'hF);
        step();
        idle(1);
        d_rd_en[1] = 2'b01;
        d_rd_addr[1][0] = 8'd1;
        step();
        d_rd_addr[1][0] = 8'd2;
        step();
        check("b2b_v1", 64'(ifB.rd_valid),      64'h1);
        check("b2b_d1", 64'(ifB.rd_data[31:0]), 64'h111);
        d_rd_addr[1][0] = 8'd3;
        wr(1, 2, 32'h00000999, 4'hF);
        step();
        check("b2b_v2", 64'(ifB.rd_valid),      64'h1);
        check("b2b_d2", 64'(ifB.rd_data[31:0]), 64'h222);
        idle(1);
        step();
        check("b2b_v3", 64'(ifB.rd_valid),      64'h1);
        check("b2b_d3", 64'(ifB.rd_data[31:0]), 64'h333);
        step();
        check("b2b_v_end", 64'(ifB.rd_valid),      64'h0);
        check("b2b_d_end", 64'(ifB.rd_data[31:0]), 64'h333);

        // B, reset pulse between sample and result edge drops the in-flight read.
        d_rd_en[1] = 2'b10;
        d_rd_addr[1][1] = 8'd199;
        step();
        idle(1);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check("rst_mid_valid", 64'(ifB.rd_valid), 64'h0);
        check("rst_mid_data",  64'(ifB.rd_data),  64'h0);
        #2;
        resetn = 1'b1;
        step();
        check("rst_drop_valid", 64'(ifB.rd_valid), 64'h0);
        check("rst_drop_data",  64'(ifB.rd_data),  64'h0);
        step();
        check("rst_drop_valid2", 64'(ifB.rd_valid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
